// File: rtl/ifetch32.sv
// Instruction fetch stage: owns the PC, registers the fetched word into decode and
// executes decoder branch redirects, flagging the wrong-path slot and BL link writes.
module ifetch32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        ib,
  input  logic [31:0] bv,
  input  logic        bl,
  output logic [31:0] iout,
  output logic [31:0] pc_out,
  output logic        ispb,
  output logic        lr_we,
  output logic [31:0] lr_val
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] iout_q, iout_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        ispb_q, ispb_d;
  logic        lr_we_q, lr_we_d;
  logic [31:0] lr_val_q, lr_val_d;

  logic        accept;
  logic [31:0] seq_pc;
  logic [31:0] target;

  // A branch is never taken from the wrong-path slot it itself squashed.
  assign accept = ib & ~ispb_q & ~stall;
  assign seq_pc = fetch_pc_q + 32'd4;
  assign target = seq_pc + bv;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    iout_d     = iout_q;
    pc_out_d   = pc_out_q;
    ispb_d     = ispb_q;
    lr_we_d    = 1'b0;
    lr_val_d   = lr_val_q;
    if (stall) begin
      lr_we_d = 1'b0;
    end else if (accept) begin
      fetch_pc_d = target;
      iout_d     = imem_data;
      pc_out_d   = fetch_pc_q;
      ispb_d     = 1'b1;
      lr_we_d    = bl;
      if (bl) begin
        lr_val_d = pc_out_q + 32'd4;
      end
    end else begin
      fetch_pc_d = seq_pc;
      iout_d     = imem_data;
      pc_out_d   = fetch_pc_q;
      ispb_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      iout_q     <= 32'h0;
      pc_out_q   <= 32'h0;
      ispb_q     <= 1'b0;
      lr_we_q    <= 1'b0;
      lr_val_q   <= 32'h0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      iout_q     <= iout_d;
      pc_out_q   <= pc_out_d;
      ispb_q     <= ispb_d;
      lr_we_q    <= lr_we_d;
      lr_val_q   <= lr_val_d;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign iout      = iout_q;
  assign pc_out    = pc_out_q;
  assign ispb      = ispb_q;
  assign lr_we     = lr_we_q;
  assign lr_val    = lr_val_q;

endmodule

// File: tb/tb_ifetch32.sv
// Directed bench for ifetch32: table of per-edge vectors plus a hand-written async reset sequence.
module tb_ifetch32;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        ib;
  logic [31:0] bv;
  logic        bl;
  logic [31:0] iout;
  logic [31:0] pc_out;
  logic        ispb;
  logic        lr_we;
  logic [31:0] lr_val;

  int n_checks = 0;
  int n_fail   = 0;

  ifetch32 #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .ib        (ib),
    .bv        (bv),
    .bl        (bl),
    .iout      (iout),
    .pc_out    (pc_out),
    .ispb      (ispb),
    .lr_we     (lr_we),
    .lr_val    (lr_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: two fixed words, an address-derived pattern elsewhere.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'hE081_0002;
    if (a == 32'h4) return 32'hE042_1003;
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A5A};
  endfunction

  assign imem_data = mem(imem_addr);

  typedef struct {
    logic        stall;
    logic        ib;
    logic        bl;
    logic [31:0] bv;
    logic [31:0] e_addr;
    logic [31:0] e_iout;
    logic [31:0] e_pc;
    logic        e_ispb;
    logic        e_lrwe;
    logic [31:0] e_lrval;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, input logic b, input logic l, input logic [31:0] off,
                     input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep,
                     input logic es, input logic ew, input logic [31:0] ev);
    vec_t v;
    v.stall = s; v.ib = b; v.bl = l; v.bv = off;
    v.e_addr = ea; v.e_iout = ei; v.e_pc = ep;
    v.e_ispb = es; v.e_lrwe = ew; v.e_lrval = ev;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] ea, input logic [31:0] ei,
                           input logic [31:0] ep, input logic es, input logic ew,
                           input logic [31:0] ev);
    check({tag, " imem_addr"}, imem_addr, ea);
    check({tag, " iout"}, iout, ei);
    check({tag, " pc_out"}, pc_out, ep);
    check({tag, " ispb"}, {31'b0, ispb}, {31'b0, es});
    check({tag, " lr_we"}, {31'b0, lr_we}, {31'b0, ew});
    check({tag, " lr_val"}, lr_val, ev);
  endtask

  initial begin
    rst_n = 1'b1;
    stall = 1'b0;
    ib    = 1'b0;
    bl    = 1'b0;
    bv    = 32'h0;

    //   stall ib bl bv            addr          iout                pc            ispb lrwe lrval
    add(0, 0, 0, 32'h0,        32'h4,        32'hE081_0002,      32'h0,        0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        32'h8,        32'hE042_1003,      32'h4,        0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        32'hC,        mem(32'h8),         32'h8,        0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        32'h10,       mem(32'hC),         32'hC,        0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        32'h14,       mem(32'h10),        32'h10,       0, 0, 32'h0);
    add(0, 1, 0, 32'h20,       32'h38,       mem(32'h14),        32'h14,       1, 0, 32'h0);
    add(0, 1, 0, 32'h100,      32'h3C,       mem(32'h38),        32'h38,       0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        32'h40,       mem(32'h3C),        32'h3C,       0, 0, 32'h0);
    add(0, 1, 0, 32'hFFFF_FFD8, 32'h1C,      mem(32'h40),        32'h40,       1, 0, 32'h0);
    add(0, 0, 0, 32'h0,        32'h20,       mem(32'h1C),        32'h1C,       0, 0, 32'h0);
    add(0, 0, 0, 32'h0,        32'h24,       mem(32'h20),        32'h20,       0, 0, 32'h0);
    add(0, 1, 1, 32'hFFFF_FFF8, 32'h20,      mem(32'h24),        32'h24,       1, 1, 32'h24);
    add(0, 0, 0, 32'h0,        32'h24,       mem(32'h20),        32'h20,       0, 0, 32'h24);
    for (int i = 0; i < 3; i++)
      add(1, 1, 0, 32'h40,     32'h24,       mem(32'h20),        32'h20,       0, 0, 32'h24);
    add(0, 1, 0, 32'h40,       32'h68,       mem(32'h24),        32'h24,       1, 0, 32'h24);
    add(1, 0, 0, 32'h0,        32'h68,       mem(32'h24),        32'h24,       1, 0, 32'h24);
    add(0, 1, 0, 32'h40,       32'h6C,       mem(32'h68),        32'h68,       0, 0, 32'h24);
    add(0, 0, 0, 32'h0,        32'h70,       mem(32'h6C),        32'h6C,       0, 0, 32'h24);
    add(0, 1, 1, 32'h0,        32'h74,       mem(32'h70),        32'h70,       1, 1, 32'h70);
    add(1, 0, 0, 32'h0,        32'h74,       mem(32'h70),        32'h70,       1, 0, 32'h70);
    add(0, 0, 0, 32'h0,        32'h78,       mem(32'h74),        32'h74,       0, 0, 32'h70);
    add(0, 1, 0, 32'hFFFF_FF80, 32'hFFFF_FFFC, mem(32'h78),      32'h78,       1, 0, 32'h70);
    add(0, 0, 0, 32'h0,        32'h0,        mem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 0, 0, 32'h70);
    add(0, 0, 0, 32'h0,        32'h4,        32'hE081_0002,      32'h0,        0, 0, 32'h70);

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1 check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      stall = vq[i].stall;
      ib    = vq[i].ib;
      bl    = vq[i].bl;
      bv    = vq[i].bv;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vq[i].e_addr, vq[i].e_iout, vq[i].e_pc,
                vq[i].e_ispb, vq[i].e_lrwe, vq[i].e_lrval);
      @(negedge clk);
    end

    // BL from pc_out=0 with fetch_pc=4, then reset dropped mid-cycle while squash and link are live.
    stall = 1'b0;
    ib    = 1'b1;
    bl    = 1'b1;
    bv    = 32'h8;
    @(posedge clk);
    #1;
    check_all("bl_pre_reset", 32'h10, 32'hE042_1003, 32'h4, 1'b1, 1'b1, 32'h4);
    ib = 1'b0;
    bl = 1'b0;
    bv = 32'h0;
    #2 rst_n = 1'b0;
    #1 check_all("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1 check_all("reset_held", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_all("post_reset", 32'h4, 32'hE081_0002, 32'h0, 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch32.md
# ifetch32

Instruction fetch stage feeding `idec32`. Owns the program counter, drives the instruction-memory read address, registers the returned word into the decode stage, and executes branch redirects reported back by the decoder. It generates the `ispb` squash flag for the wrong-path slot and a one-cycle link-register write request for `BL`.

## Interface

- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset. Must be word aligned.
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `stall`  in  1: hold request from downstream. Freezes all fetch state.
- `imem_addr`  out  32: instruction-memory read address, equal to the internal `fetch_pc`.
- `imem_data`  in  32: instruction word at `imem_addr`, combinational read, valid in the same cycle.
- `ib`  in  1: branch taken, from the decoder.
- `bv`  in  32: sign-extended byte offset, already shifted left by 2, from the decoder.
- `bl`  in  1: branch-with-link, from the decoder.
- `iout`  out  32: instruction in decode. Connects to decoder `iin`.
- `pc_out`  out  32: address of the instruction on `iout`.
- `ispb`  out  1: previous instruction was a taken branch, so `iout` is wrong-path. Connects to decoder `ispb`.
- `lr_we`  out  1: one-cycle request to write `lr_val` into r14.
- `lr_val`  out  32: return address for `BL`.

## Operation

- Registers: `fetch_pc`, `iout`, `pc_out`, `ispb`, `lr_we`, `lr_val`.
- Invariant when not redirecting: `fetch_pc == pc_out + 4`.
- `accept = ib & ~ispb & ~stall`. `ib` is ignored while `ispb=1`, as a defensive measure, and while `stall=1`.
- `target = fetch_pc + 4 + bv`. This equals branch address + 8 + offset, per ARM PC semantics.
- Each edge, by priority:
  - `stall=1`:
    - `fetch_pc`, `iout`, `pc_out`, `ispb`, `lr_val` hold.
    - `lr_we <= 0`.
  - `accept=1`:
    - `fetch_pc <= target`.
    - `iout <= imem_data` (the wrong-path word).
    - `pc_out <= fetch_pc`.
    - `ispb <= 1`.
    - `lr_we <= bl`.
    - `lr_val <= pc_out + 4` if `bl`, otherwise hold.
  - Otherwise:
    - `fetch_pc <= fetch_pc + 4`.
    - `iout <= imem_data`.
    - `pc_out <= fetch_pc`.
    - `ispb <= 0`.
    - `lr_we <= 0`.
- All arithmetic is 32-bit, modulo 2^32. Wrap from `FFFF_FFFC` to `0000_0000` is silent.
- No alignment fix-up is applied. Targets stay aligned because `bv[1:0]` is always 0.

## Timing

- Reset values, applied asynchronously on `rst_n=0`:
  - `fetch_pc`/`imem_addr` = `RESET_PC`.
  - `iout` = 0 (the decoder treats 0 as a no-op).
  - `pc_out` = 0.
  - `ispb` = 0.
  - `lr_we` = 0.
  - `lr_val` = 0.
- First edge after reset release: `iout = mem[RESET_PC]`, `pc_out = RESET_PC`.
- Fetch-to-decode latency is 1 cycle. Throughput is 1 instruction per cycle when there is no stall or branch.
- Branch at address A with `ib` seen in cycle n:
  - Cycle n+1: `ispb=1`, `iout = mem[A+4]` (squashed), `imem_addr = target`, `lr_we = bl`.
  - Cycle n+2: `iout = mem[target]`, `pc_out = target`, `ispb=0`.
  - Penalty is 1 bubble.
- Stall during the squash cycle: `ispb` stays 1 until the first non-stalled edge.
- A branch held under `stall` is accepted on the first edge with `stall=0`. The decoder output stays stable because `iout` is held.
- `rst_n` asserted mid-branch or mid-stall: the pending redirect, squash, and link are discarded immediately, without waiting for a clock edge.

## Test plan

- Sequential fetch: `RESET_PC=0`, mem[0]=`E0810002`, mem[4]=`E0421003`, release reset. Required response:
  - Edge 1: `iout=E0810002`, `pc_out=0`, `imem_addr=4`.
  - Edge 2: `iout=E0421003`, `pc_out=4`.
  - `ispb=0` throughout.
- Forward branch: `pc_out=0x10`, force `ib=1`, `bv=0x20`, `bl=0`. Required response:
  - Next cycle: `ispb=1`, `iout=mem[0x14]`, `imem_addr=0x38`, `lr_we=0`.
  - Following cycle: `iout=mem[0x38]`, `pc_out=0x38`, `ispb=0`.
- BL to self: `pc_out=0x20`, `ib=1`, `bl=1`, `bv=FFFF_FFF8`. Required response:
  - `lr_we=1` for exactly 1 cycle with `lr_val=0x24`.
  - `imem_addr=0x20`, then `pc_out=0x20`.
- Stall: `stall=1` for 3 cycles with `ib=1` asserted throughout. Required response:
  - `imem_addr`, `iout`, `pc_out` unchanged and `lr_we=0` during the stall.
  - Redirect happens on the first edge after `stall` drops.
  - While `ispb=1`, a concurrent `ib=1` is ignored and `fetch_pc` increments normally.
- Wrap: `fetch_pc=FFFF_FFFC`, no branch. Required response: next `imem_addr=0000_0000`, `pc_out=FFFF_FFFC`.
- Async reset: drop `rst_n` mid-cycle while `ispb=1` and `lr_we=1`. Required response: all outputs reach reset values before the next `clk` edge, and `imem_addr=RESET_PC`.
